// File: rtl/rx_frame_sr.sv
// rx_frame_sr: parametrised receive-frame shift register with a one-entry
// valid/ready holding buffer. Serial bits shift in from the MSB end on
// shift_strobe. On packet_done the frame is checked for parity and stop bits
// and stored for the consumer.
// Optional feature macro: RX_FRAME_SR_OVERRUN_CNT_EN adds overrun_count[7:0],
// a saturating count of dropped frames.
// Handshake: the held frame is offered while data_valid = 1 and is consumed
// at any clk edge where data_valid && data_ready. packet_data, parity_error
// and framing_error do not change while data_valid = 1 unless that same edge
// pops the entry.
module rx_frame_sr #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0,
    parameter int MSB_FIRST   = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 shift_strobe,
    input  logic                 serial_in,
    input  logic                 packet_done,
    input  logic                 data_ready,
    input  logic                 clear_errors,
    output logic [DATA_BITS-1:0] packet_data,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun_error
`ifdef RX_FRAME_SR_OVERRUN_CNT_EN
    ,
    output logic [7:0]           overrun_count
`endif
);

    localparam int PAR_BITS   = (PARITY_MODE != 0) ? 1 : 0;
    localparam int FRAME_BITS = DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_next;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    logic [DATA_BITS-1:0]  raw_data, cap_data;
    logic [STOP_BITS-1:0]  stop_field;
    logic                  par_bit, par_sum, cap_perr, cap_ferr;
    logic                  pop, load, overrun;

    // Shifter, bit counter and COLLECT/FULL controller; the count saturates
    // in FULL while the shifter keeps shifting.
    always_comb begin
        shift_d  = shift_q;
        cnt_next = cnt_q;
        if (shift_strobe) begin
            shift_d = {serial_in, shift_q[FRAME_BITS-1:1]};
            if (state_q != ST_FULL) begin
                cnt_next = cnt_q + 1'b1;
            end
        end
        if (packet_done) begin
            cnt_d   = '0;
            state_d = ST_COLLECT;
        end else begin
            cnt_d   = cnt_next;
            state_d = (cnt_next == CNT_FULL) ? ST_FULL : ST_COLLECT;
        end
    end

    // Frame decode from the post-shift value so a same-cycle strobe is included.
    always_comb begin
        raw_data = shift_d[DATA_BITS-1:0];
        cap_data = raw_data;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < DATA_BITS; i++) begin
                cap_data[i] = raw_data[DATA_BITS-1-i];
            end
        end
        par_bit    = (PARITY_MODE != 0) ? shift_d[DATA_BITS] : 1'b0;
        par_sum    = (^raw_data) ^ par_bit;
        cap_perr   = 1'b0;
        if (PARITY_MODE == 1) begin
            cap_perr = par_sum;
        end else if (PARITY_MODE == 2) begin
            cap_perr = ~par_sum;
        end
        stop_field = shift_d[FRAME_BITS-1 -: STOP_BITS];
        cap_ferr   = ~(&stop_field) | (cnt_next != CNT_FULL);
    end

    // Holding buffer: a pop frees the slot in time for a same-cycle capture.
    always_comb begin
        pop     = valid_q & data_ready;
        load    = packet_done & (~valid_q | pop);
        overrun = packet_done & valid_q & ~pop;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = cap_data;
            perr_d  = cap_perr;
            ferr_d  = cap_ferr;
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
        ovr_d = ovr_q;
        if (overrun) begin
            ovr_d = 1'b1;
        end else if (clear_errors) begin
            ovr_d = 1'b0;
        end
    end

    // State registers; reset discards partial bits and the held frame.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= ST_COLLECT;
            shift_q <= '1;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign packet_data   = data_q;
    assign data_valid    = valid_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign overrun_error = ovr_q;

`ifdef RX_FRAME_SR_OVERRUN_CNT_EN
    logic [7:0] ocnt_q, ocnt_d;

    // Saturating dropped-frame count; a new overrun beats clear_errors.
    always_comb begin
        ocnt_d = ocnt_q;
        if (overrun) begin
            if (clear_errors) begin
                ocnt_d = 8'd1;
            end else if (ocnt_q != 8'hFF) begin
                ocnt_d = ocnt_q + 8'd1;
            end
        end else if (clear_errors) begin
            ocnt_d = 8'd0;
        end
    end

    // Dropped-frame counter register.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            ocnt_q <= 8'd0;
        end else begin
            ocnt_q <= ocnt_d;
        end
    end

    assign overrun_count = ocnt_q;
`endif

endmodule

// File: doc/rx_frame_sr.md
Name: rx_frame_sr

Overview:
Parametrised receive-frame shift register, the successor to the fixed 9-bit receive shifter. It shifts serial bits on a strobe from the timing block and assembles a frame of data, optional parity and 1–2 stop bits. On packet_done it checks the frame and places the result in a one-entry holding buffer with a valid/ready handshake. It sits between the receive timer/controller and the receive FIFO.

Parameters:
DATA_BITS, 8, data bits per frame (5..16).
STOP_BITS, 1, stop bits per frame (1 or 2).
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
MSB_FIRST, 0, 0 = first received data bit is packet_data[0]; 1 = first received bit is packet_data[DATA_BITS-1].

Ports:
clk  in  1  system clock.
n_rst  in  1  reset. Synchronous, active-high (asserted = 1); name kept for codebase consistency.
shift_strobe  in  1  one-cycle pulse: sample serial_in into the shifter.
serial_in  in  1  receive line bit.
packet_done  in  1  one-cycle pulse: frame complete, capture it.
data_ready  in  1  consumer accepts the held frame.
clear_errors  in  1  clears the sticky overrun_error.
packet_data  out  DATA_BITS  captured data.
data_valid  out  1  holding buffer full.
parity_error  out  1  parity mismatch for the held frame.
framing_error  out  1  a stop bit was 0, or the bit count was wrong, for the held frame.
overrun_error  out  1  sticky: a frame was dropped.

Behaviour:
- Reset, n_rst = 1 at a clk edge:
  - Shifter goes to all ones; bit_cnt goes to 0.
  - packet_data, data_valid, parity_error, framing_error and overrun_error all go to 0.
  - Reset overrides every other input in that cycle.
- Sizing: FRAME_BITS = DATA_BITS + (PARITY_MODE != 0) + STOP_BITS.
  - The shifter is FRAME_BITS wide and shifts right; serial_in enters the MSB.
  - After FRAME_BITS strobes, the first received bit is at bit 0.
- bit_cnt has width $clog2(FRAME_BITS+1), counts shift_strobe pulses and saturates at FRAME_BITS. Strobes beyond that still shift, so the oldest bits are lost.
- Controller states:
  - COLLECT: bit_cnt < FRAME_BITS.
  - FULL: bit_cnt == FRAME_BITS.
  - packet_done in either state performs a capture and returns to COLLECT with bit_cnt = 0. The shifter is not cleared.
- Capture timing: capture uses the post-shift value. If shift_strobe and packet_done arrive in the same cycle, the new bit is included and counted.
- Frame field layout after capture, bit 0 upward: data[DATA_BITS-1:0], then parity (if enabled), then stop bits.
- MSB_FIRST = 1: the data field is bit-reversed on capture.
- parity_error (PARITY_MODE 1/2): XOR over data and parity bit ≠ 0 for even, ≠ 1 for odd. Forced to 0 when PARITY_MODE = 0.
- framing_error = (any stop bit == 0) OR (bit_cnt ≠ FRAME_BITS at capture).
- Outputs are registered; capture results appear the cycle after packet_done. Latency from the last strobe to data_valid is 1 cycle.
- Handshake:
  - Pop: data_valid && data_ready at an edge clears data_valid next cycle.
  - packet_data, parity_error and framing_error stay stable while data_valid = 1.
  - While data_valid = 0, packet_data holds its last value.
- Buffer full: packet_done while data_valid = 1 and no pop in the same cycle:
  - The new frame is dropped and the held frame is kept.
  - overrun_error is set to 1; bit_cnt still resets to 0.
- Pop and packet_done in the same cycle: the new frame loads, data_valid stays 1, no overrun.
- overrun_error is sticky. clear_errors clears it; if clear_errors and a new overrun occur in the same cycle, the overrun wins and the flag is 1.
- Reset mid-frame discards partial bits and the held frame.

Optional Feature:
- Macro: RX_FRAME_SR_OVERRUN_CNT_EN.
- When defined:
  - Adds output overrun_count [7:0], a saturating count of dropped frames (saturates at 255).
  - Reset and clear_errors set it to 0; clear_errors and an overrun in the same cycle give 1.
- When undefined: the port is absent and no counter logic exists. All other behaviour is identical.

Test Plan:
- Defaults, bits 1,0,1,0,0,1,0,1 then stop 1, packet_done, data_ready = 0 -> next cycle packet_data = 0xA5, data_valid = 1, parity_error = 0, framing_error = 0; data_valid holds until data_ready = 1, then drops 1 cycle later.
- PARITY_MODE = 1, data 0x07 sent LSB-first, parity 1, stop 1 -> parity_error = 0. Repeat with parity 0 -> parity_error = 1. PARITY_MODE = 2 with parity 0 -> parity_error = 0.
- Defaults, stop bit 0 -> framing_error = 1, packet_data = data bits. Only 6 strobes before packet_done -> framing_error = 1.
- MSB_FIRST = 1, DATA_BITS = 8, bits 1,0,1,0,0,1,0,1,stop 1 -> packet_data = 0xA5 bit-reversed = 0xA5 (palindrome). Then 0x01 pattern (1,0,0,0,0,0,0,0) -> 0x80.
- Two frames 0x11 then 0x22, no data_ready -> packet_data stays 0x11, overrun_error = 1 (overrun_count = 1 if enabled). A third frame with data_ready asserted in the packet_done cycle -> packet_data = the third frame's data, data_valid stays 1. clear_errors -> overrun_error = 0.
- n_rst = 1 after 4 strobes, then a full 0x3C frame -> packet_data = 0x3C, framing_error = 0 (partial bits discarded, bit_cnt restarted).
